// File: rtl/vc_arbiter_ctrl_if.sv
// Signal bundle between the VC arbiter controller and its FIFO environment.
// The master modport is the controller; the slave modport is the FIFO side.
interface vc_arbiter_ctrl_if #(
    parameter int unsigned DATA_SIZE = 6
);
    logic                 init;
    logic [3:0]           afVC_in;
    logic [3:0]           aeVC_in;
    logic                 fifo_empty_vc0;
    logic                 fifo_empty_vc1;
    logic [DATA_SIZE-1:0] data_vc0;
    logic [DATA_SIZE-1:0] data_vc1;
    logic                 fifo_pause_d0;
    logic                 fifo_pause_d1;
    logic [3:0]           afVC_o;
    logic [3:0]           aeVC_o;
    logic                 pop_vc0;
    logic                 pop_vc1;
    logic                 push_d0;
    logic                 push_d1;
    logic [DATA_SIZE-1:0] data_out;
    logic [1:0]           state;
    logic                 idle;

    modport master (
        input  init, afVC_in, aeVC_in, fifo_empty_vc0, fifo_empty_vc1,
        input  data_vc0, data_vc1, fifo_pause_d0, fifo_pause_d1,
        output afVC_o, aeVC_o, pop_vc0, pop_vc1, push_d0, push_d1,
        output data_out, state, idle
    );

    modport slave (
        output init, afVC_in, aeVC_in, fifo_empty_vc0, fifo_empty_vc1,
        output data_vc0, data_vc1, fifo_pause_d0, fifo_pause_d1,
        input  afVC_o, aeVC_o, pop_vc0, pop_vc1, push_d0, push_d1,
        input  data_out, state, idle
    );
endinterface

// File: rtl/vc_arbiter_ctrl.sv
// VC arbiter controller: programs VC FIFO thresholds, round-robins pops
// between VC0/VC1 and routes each popped word to D0/D1 two cycles later.
module vc_arbiter_ctrl #(
    parameter int unsigned DATA_SIZE = 6,
    parameter int unsigned DEST_BIT  = 4
) (
    input logic                clk,
    input logic                reset_L,
    vc_arbiter_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        StReset  = 2'b00,
        StInit   = 2'b01,
        StIdle   = 2'b10,
        StActive = 2'b11
    } state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic [3:0]           r_af;
    logic [3:0]           r_ae;
    logic                 r_push_d0;
    logic                 r_push_d1;
    logic [DATA_SIZE-1:0] r_data_out;
    // Round-robin pointer: 0 favours VC0, 1 favours VC1.
    logic                 r_rr;
    logic                 w_rr_next;
    // Stage 1: a pop was issued last cycle; its read data is valid now.
    logic                 r_s1_valid;
    logic                 r_s1_src;
    logic                 w_pop0;
    logic                 w_pop1;
    logic                 w_ne0;
    logic                 w_ne1;
    logic                 w_gate;
    logic [DATA_SIZE-1:0] w_word;

    assign w_ne0 = !bus.fifo_empty_vc0;
    assign w_ne1 = !bus.fifo_empty_vc1;
    // Destination is unknown until the word is read, so either pause blocks pops.
    assign w_gate = (r_state == StActive) && !bus.init &&
                    !bus.fifo_pause_d0 && !bus.fifo_pause_d1;
    assign w_word = r_s1_src ? bus.data_vc1 : bus.data_vc0;

    // State register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= StReset;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StReset: w_state_next = StInit;
            StInit: begin
                if (!bus.init) w_state_next = StIdle;
            end
            StIdle: begin
                if (bus.init)            w_state_next = StInit;
                else if (w_ne0 || w_ne1) w_state_next = StActive;
            end
            StActive: begin
                if (bus.init)                                   w_state_next = StInit;
                else if (!w_ne0 && !w_ne1 && !r_s1_valid)       w_state_next = StIdle;
            end
            default: w_state_next = StReset;
        endcase
    end

    // Round-robin pop selection; at most one pop per cycle.
    always_comb begin
        w_pop0    = 1'b0;
        w_pop1    = 1'b0;
        w_rr_next = r_rr;
        if (w_gate) begin
            if (w_ne0 && w_ne1) begin
                w_pop0    = !r_rr;
                w_pop1    = r_rr;
                w_rr_next = !r_rr;
            end else if (w_ne0) begin
                w_pop0    = 1'b1;
                w_rr_next = 1'b1;
            end else if (w_ne1) begin
                w_pop1    = 1'b1;
                w_rr_next = 1'b0;
            end
        end
    end

    // Threshold registers, loaded only while configuring.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_af <= 4'd0;
            r_ae <= 4'd0;
        end else if ((r_state == StInit) && bus.init) begin
            r_af <= bus.afVC_in;
            r_ae <= bus.aeVC_in;
        end
    end

    // Arbitration pointer and pop-to-read pipeline stage.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_rr       <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_src   <= 1'b0;
        end else begin
            r_rr       <= w_rr_next;
            r_s1_valid <= w_pop0 || w_pop1;
            r_s1_src   <= w_pop1;
        end
    end

    // Route the read word to D0/D1 by its destination bit; data_out holds otherwise.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_push_d0  <= 1'b0;
            r_push_d1  <= 1'b0;
            r_data_out <= '0;
        end else if (r_s1_valid) begin
            r_push_d0  <= !w_word[DEST_BIT];
            r_push_d1  <= w_word[DEST_BIT];
            r_data_out <= w_word;
        end else begin
            r_push_d0  <= 1'b0;
            r_push_d1  <= 1'b0;
        end
    end

    assign bus.afVC_o   = r_af;
    assign bus.aeVC_o   = r_ae;
    assign bus.pop_vc0  = w_pop0;
    assign bus.pop_vc1  = w_pop1;
    assign bus.push_d0  = r_push_d0;
    assign bus.push_d1  = r_push_d1;
    assign bus.data_out = r_data_out;
    assign bus.state    = r_state;
    assign bus.idle     = (r_state == StIdle) && !w_ne0 && !w_ne1 && !r_s1_valid;

endmodule

// File: tb/tb_vc_arbiter_ctrl.sv
// Self-checking bench for vc_arbiter_ctrl: a per-cycle vector table with the
// VC flags driven directly, then multi-cycle sequences against a VC FIFO model.
module tb_vc_arbiter_ctrl;

    logic clk;
    logic reset_L;

    vc_arbiter_ctrl_if #(.DATA_SIZE(6)) bus ();

    vc_arbiter_ctrl #(.DATA_SIZE(6), .DEST_BIT(4)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       init;
        logic [3:0] af_in;
        logic [3:0] ae_in;
        logic       e0;
        logic       e1;
        logic       pz0;
        logic       pz1;
        logic [5:0] d0;
        logic [5:0] d1;
        logic [1:0] x_state;
        logic       x_pop0;
        logic       x_pop1;
        logic       x_push0;
        logic       x_push1;
        logic [5:0] x_dout;
        logic [3:0] x_af;
        logic [3:0] x_ae;
        logic       x_idle;
    } vec_t;

    vec_t vecs [17];

    int n_checks = 0;
    int n_errors = 0;
    int cyc_cnt  = 0;
    bit use_model = 1'b0;

    logic [5:0] q0 [$];
    logic [5:0] q1 [$];
    int         pop_log [$];
    logic [6:0] push_log [$];
    int         push_cyc [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: log pops before the edge, update the FIFO model and log pushes after it.
    task automatic cyc();
        logic p0;
        logic p1;
        #1;
        p0 = bus.pop_vc0;
        p1 = bus.pop_vc1;
        if (p0) pop_log.push_back(0);
        if (p1) pop_log.push_back(1);
        @(posedge clk);
        #1;
        cyc_cnt++;
        if (use_model) begin
            if (p0 && q0.size() > 0) bus.data_vc0 = q0.pop_front();
            if (p1 && q1.size() > 0) bus.data_vc1 = q1.pop_front();
            bus.fifo_empty_vc0 = (q0.size() == 0);
            bus.fifo_empty_vc1 = (q1.size() == 0);
        end
        #1;
        if (bus.push_d0) begin
            push_log.push_back({1'b0, bus.data_out});
            push_cyc.push_back(cyc_cnt);
        end
        if (bus.push_d1) begin
            push_log.push_back({1'b1, bus.data_out});
            push_cyc.push_back(cyc_cnt);
        end
    endtask

    task automatic clear_logs();
        pop_log.delete();
        push_log.delete();
        push_cyc.delete();
    endtask

    task automatic sync_flags();
        bus.fifo_empty_vc0 = (q0.size() == 0);
        bus.fifo_empty_vc1 = (q1.size() == 0);
    endtask

    task automatic reset_init();
        reset_L           = 1'b0;
        bus.init          = 1'b0;
        bus.fifo_pause_d0 = 1'b0;
        bus.fifo_pause_d1 = 1'b0;
        q0.delete();
        q1.delete();
        sync_flags();
        cyc();
        reset_L     = 1'b1;
        bus.init    = 1'b1;
        bus.afVC_in = 4'd3;
        bus.aeVC_in = 4'd1;
        repeat (3) cyc();
        bus.init = 1'b0;
        repeat (2) cyc();
    endtask

    // Run until the pop log reaches n entries, bounded.
    task automatic run_until_pops(input string name, input int n);
        int k;
        k = 0;
        while (pop_log.size() < n && k < 12) begin
            cyc();
            k++;
        end
        chk(name, 32'(pop_log.size() >= n), 32'd1);
    endtask

    initial begin
        logic [6:0] exp_rr [4];
        logic [6:0] exp_in [4];
        int         np;
        int         nq;
        int         diff;

        //          init af    ae    e0 e1 pz0 pz1 d0     d1     st    p0 p1 u0 u1 dout   af    ae    idle
        vecs[0]  = '{1'b1, 4'd3, 4'd1, 1, 1, 0, 0, 6'h00, 6'h00, 2'd0, 0, 0, 0, 0, 6'h00, 4'd0, 4'd0, 0};
        vecs[1]  = '{1'b1, 4'd3, 4'd1, 1, 1, 0, 0, 6'h00, 6'h00, 2'd1, 0, 0, 0, 0, 6'h00, 4'd0, 4'd0, 0};
        vecs[2]  = '{1'b1, 4'd3, 4'd1, 1, 1, 0, 0, 6'h00, 6'h00, 2'd1, 0, 0, 0, 0, 6'h00, 4'd3, 4'd1, 0};
        vecs[3]  = '{1'b0, 4'd3, 4'd1, 1, 1, 0, 0, 6'h00, 6'h00, 2'd1, 0, 0, 0, 0, 6'h00, 4'd3, 4'd1, 0};
        vecs[4]  = '{1'b0, 4'd9, 4'd6, 1, 1, 0, 0, 6'h00, 6'h00, 2'd2, 0, 0, 0, 0, 6'h00, 4'd3, 4'd1, 1};
        vecs[5]  = '{1'b0, 4'd9, 4'd6, 0, 1, 0, 0, 6'h00, 6'h00, 2'd2, 0, 0, 0, 0, 6'h00, 4'd3, 4'd1, 0};
        vecs[6]  = '{1'b0, 4'd9, 4'd6, 0, 1, 0, 0, 6'h00, 6'h00, 2'd3, 1, 0, 0, 0, 6'h00, 4'd3, 4'd1, 0};
        vecs[7]  = '{1'b0, 4'd9, 4'd6, 1, 1, 0, 0, 6'h10, 6'h00, 2'd3, 0, 0, 0, 0, 6'h00, 4'd3, 4'd1, 0};
        vecs[8]  = '{1'b0, 4'd9, 4'd6, 1, 1, 0, 0, 6'h00, 6'h00, 2'd3, 0, 0, 0, 1, 6'h10, 4'd3, 4'd1, 0};
        vecs[9]  = '{1'b0, 4'd9, 4'd6, 1, 1, 0, 0, 6'h00, 6'h00, 2'd2, 0, 0, 0, 0, 6'h10, 4'd3, 4'd1, 1};
        vecs[10] = '{1'b0, 4'd9, 4'd6, 0, 0, 0, 1, 6'h00, 6'h00, 2'd2, 0, 0, 0, 0, 6'h10, 4'd3, 4'd1, 0};
        vecs[11] = '{1'b0, 4'd9, 4'd6, 0, 0, 0, 1, 6'h00, 6'h00, 2'd3, 0, 0, 0, 0, 6'h10, 4'd3, 4'd1, 0};
        vecs[12] = '{1'b0, 4'd9, 4'd6, 0, 0, 0, 0, 6'h00, 6'h00, 2'd3, 0, 1, 0, 0, 6'h10, 4'd3, 4'd1, 0};
        vecs[13] = '{1'b0, 4'd9, 4'd6, 0, 0, 0, 0, 6'h00, 6'h05, 2'd3, 1, 0, 0, 0, 6'h10, 4'd3, 4'd1, 0};
        vecs[14] = '{1'b0, 4'd9, 4'd6, 1, 1, 0, 0, 6'h33, 6'h05, 2'd3, 0, 0, 1, 0, 6'h05, 4'd3, 4'd1, 0};
        vecs[15] = '{1'b0, 4'd9, 4'd6, 1, 1, 0, 0, 6'h00, 6'h00, 2'd3, 0, 0, 0, 1, 6'h33, 4'd3, 4'd1, 0};
        vecs[16] = '{1'b0, 4'd9, 4'd6, 1, 1, 0, 0, 6'h00, 6'h00, 2'd2, 0, 0, 0, 0, 6'h33, 4'd3, 4'd1, 1};

        reset_L            = 1'b0;
        bus.init           = 1'b0;
        bus.afVC_in        = 4'd0;
        bus.aeVC_in        = 4'd0;
        bus.fifo_empty_vc0 = 1'b1;
        bus.fifo_empty_vc1 = 1'b1;
        bus.data_vc0       = 6'h00;
        bus.data_vc1       = 6'h00;
        bus.fifo_pause_d0  = 1'b0;
        bus.fifo_pause_d1  = 1'b0;
        repeat (2) cyc();
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_idle", 32'(bus.idle), 32'd0);
        chk("rst_push", 32'({bus.push_d0, bus.push_d1}), 32'd0);
        reset_L = 1'b1;

        // Per-cycle vectors: flags driven directly, outputs checked before each edge.
        for (int i = 0; i < 17; i++) begin
            bus.init           = vecs[i].init;
            bus.afVC_in        = vecs[i].af_in;
            bus.aeVC_in        = vecs[i].ae_in;
            bus.fifo_empty_vc0 = vecs[i].e0;
            bus.fifo_empty_vc1 = vecs[i].e1;
            bus.fifo_pause_d0  = vecs[i].pz0;
            bus.fifo_pause_d1  = vecs[i].pz1;
            bus.data_vc0       = vecs[i].d0;
            bus.data_vc1       = vecs[i].d1;
            #1;
            chk($sformatf("v%0d_state", i), 32'(bus.state), 32'(vecs[i].x_state));
            chk($sformatf("v%0d_pop0", i), 32'(bus.pop_vc0), 32'(vecs[i].x_pop0));
            chk($sformatf("v%0d_pop1", i), 32'(bus.pop_vc1), 32'(vecs[i].x_pop1));
            chk($sformatf("v%0d_push0", i), 32'(bus.push_d0), 32'(vecs[i].x_push0));
            chk($sformatf("v%0d_push1", i), 32'(bus.push_d1), 32'(vecs[i].x_push1));
            chk($sformatf("v%0d_dout", i), 32'(bus.data_out), 32'(vecs[i].x_dout));
            chk($sformatf("v%0d_af", i), 32'(bus.afVC_o), 32'(vecs[i].x_af));
            chk($sformatf("v%0d_ae", i), 32'(bus.aeVC_o), 32'(vecs[i].x_ae));
            chk($sformatf("v%0d_idle", i), 32'(bus.idle), 32'(vecs[i].x_idle));
            cyc();
        end

        // Round-robin with the FIFO model.
        use_model = 1'b1;
        reset_init();
        chk("rr_pre_idle", 32'(bus.idle), 32'd1);
        clear_logs();
        q0.push_back(6'h01); q0.push_back(6'h02);
        q1.push_back(6'h03); q1.push_back(6'h04);
        sync_flags();
        repeat (12) cyc();
        exp_rr[0] = 7'h01; exp_rr[1] = 7'h03; exp_rr[2] = 7'h02; exp_rr[3] = 7'h04;
        chk("rr_pop_count", 32'(pop_log.size()), 32'd4);
        if (pop_log.size() == 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("rr_pop%0d", i), 32'(pop_log[i]), 32'(i % 2));
        end
        chk("rr_push_count", 32'(push_log.size()), 32'd4);
        if (push_log.size() == 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("rr_push%0d", i), 32'(push_log[i]), 32'(exp_rr[i]));
            chk("rr_back_to_back", 32'(push_cyc[3] - push_cyc[0]), 32'd3);
        end
        chk("rr_end_state", 32'(bus.state), 32'd2);

        // Destination pause mid-stream.
        clear_logs();
        for (int i = 1; i <= 6; i++) q0.push_back(6'(i));
        sync_flags();
        run_until_pops("pause_reach", 2);
        bus.fifo_pause_d1 = 1'b1;
        #1;
        chk("pause_pop_now", 32'(bus.pop_vc0), 32'd0);
        np = pop_log.size();
        nq = push_log.size();
        repeat (4) cyc();
        chk("pause_no_pops", 32'(pop_log.size()), 32'(np));
        diff = push_log.size() - nq;
        chk("pause_inflight", 32'(diff >= 1 && diff <= 2), 32'd1);
        bus.fifo_pause_d1 = 1'b0;
        #1;
        chk("pause_resume", 32'(bus.pop_vc0), 32'd1);
        repeat (14) cyc();
        chk("pause_push_count", 32'(push_log.size()), 32'd6);
        if (push_log.size() == 6) begin
            for (int i = 0; i < 6; i++) chk($sformatf("pause_push%0d", i), 32'(push_log[i]), 32'(i + 1));
        end

        // Init request while words are queued.
        clear_logs();
        q0.push_back(6'h07); q0.push_back(6'h18); q0.push_back(6'h0A); q0.push_back(6'h1B);
        sync_flags();
        run_until_pops("init_reach", 2);
        bus.init    = 1'b1;
        bus.afVC_in = 4'd5;
        bus.aeVC_in = 4'd2;
        #1;
        chk("init_pop_stop", 32'(bus.pop_vc0), 32'd0);
        cyc();
        chk("init_state", 32'(bus.state), 32'd1);
        repeat (2) cyc();
        chk("init_pop_frozen", 32'(pop_log.size()), 32'd2);
        chk("init_inflight_done", 32'(push_log.size()), 32'd2);
        chk("init_af", 32'(bus.afVC_o), 32'd5);
        chk("init_ae", 32'(bus.aeVC_o), 32'd2);
        bus.init = 1'b0;
        cyc();
        chk("init_to_idle", 32'(bus.state), 32'd2);
        cyc();
        chk("init_to_active", 32'(bus.state), 32'd3);
        repeat (10) cyc();
        exp_in[0] = 7'h07; exp_in[1] = 7'h58; exp_in[2] = 7'h0A; exp_in[3] = 7'h5B;
        chk("init_push_count", 32'(push_log.size()), 32'd4);
        if (push_log.size() == 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("init_push%0d", i), 32'(push_log[i]), 32'(exp_in[i]));
        end
        chk("init_end_state", 32'(bus.state), 32'd2);

        // Asynchronous reset between a pop and its push.
        clear_logs();
        q0.push_back(6'h01);
        sync_flags();
        run_until_pops("arst_reach", 1);
        #1;
        reset_L = 1'b0;
        #1;
        chk("arst_state", 32'(bus.state), 32'd0);
        chk("arst_push", 32'({bus.push_d0, bus.push_d1}), 32'd0);
        chk("arst_dout", 32'(bus.data_out), 32'd0);
        chk("arst_af", 32'(bus.afVC_o), 32'd0);
        repeat (2) cyc();
        reset_L = 1'b1;
        repeat (6) cyc();
        chk("arst_no_push", 32'(push_log.size()), 32'd0);
        chk("arst_state_after", 32'(bus.state), 32'd2);
        chk("arst_idle_after", 32'(bus.idle), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
